mem_access_unit: RTL and testbench

- Initiator side of the data-memory port: the load/store engine that drives a byte-addressed, big-endian, word-wide data memory.
- The memory has combinational read data for the presented address and a synchronous write on posedge when write-enable is high.
- Accepts byte, half and word load/store requests from the core pipeline. Aligns addresses, extracts and extends load data, and performs read-modify-write for sub-word stores.
- Flags misaligned and out-of-range requests without touching memory.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store engine for a byte-addressed, big-endian, word-wide data memory.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              bad;
    logic [ADDR_W:0]   nbytes;
    logic [1:0]        lane;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign accept = req_valid && (state == IDLE);
    assign lane   = ~addr_q[1:0];

    always_comb begin
        nbytes = (ADDR_W+1)'(4);
        unique case (req_size)
            2'b00:   nbytes = (ADDR_W+1)'(1);
            2'b01:   nbytes = (ADDR_W+1)'(2);
            default: nbytes = (ADDR_W+1)'(4);
        endcase
    end

    // Range check is one bit wider so addresses near the top cannot wrap.
    assign bad = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && |req_addr[1:0])
               || ({1'b0, req_addr} + nbytes > LIMIT);

    always_comb begin
        rbyte    = mem_rdata[{lane, 3'b000} +: 8];
        rhalf    = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        load_val = mem_rdata;
        unique case (size_q)
            2'b00:   load_val = {{24{sgn_q & rbyte[7]}}, rbyte};
            2'b01:   load_val = {{16{sgn_q & rhalf[15]}}, rhalf};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        unique case (size_q)
            2'b00: merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[15:0] = wdata_q[15:0];
                else           merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad)                                 state_d = RESP;
                    else if (req_write && req_size == 2'b10) state_d = WRITE;
                    else                                     state_d = READ;
                end
            end
            READ:    state_d = wr_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                wr_q    <= req_write;
                wdata_q <= req_wdata;
                if (bad) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (state == READ) begin
                word_q <= mem_rdata;
                if (!wr_q) begin
                    rdata_q <= load_val;
                    err_q   <= 1'b0;
                end
            end
            if (state == WRITE) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Bus outputs decode from state so an async reset drops them at once.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state == WRITE);
    assign mem_addr   = (state == READ || state == WRITE)
                      ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = (state == WRITE) ? merged : '0;

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (wr_q) begin
                if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
            end else begin
                if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference memory, directed
// plan steps followed by randomized load/store traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
`endif

    mem_access_unit #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
        , .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory attached to the unit, plus a preload port used under reset.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    logic [7:0] rm [0:1023];
    int tests = 0;
    int fails = 0;
    int m_loads = 0, m_stores = 0, m_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {rm[b], rm[b+1], rm[b+2], rm[b+3]};
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd);
        int nb, e_lat, cyc, wecnt;
        logic e_err, got;
        logic [31:0] e_rd, e_word, we_addr, we_data, v;
        longint top;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        top = longint'(a) + nb;
        e_err = (sz == 2'd3) || ((a % nb) != 0) || (top > 1024);
        e_rd = 0;
        e_word = 0;
        if (e_err) e_lat = 1;
        else if (w) e_lat = (sz == 2'd2) ? 2 : 3;
        else e_lat = 2;
        if (!e_err && w) begin
            for (int i = 0; i < nb; i++)
                rm[a + i] = 8'((wd >> (8 * (nb - 1 - i))) & 32'hFF);
            e_word = ref_word(int'(a));
        end
        if (!e_err && !w) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(rm[a + i]);
            if (sg && nb < 4 && v[8 * nb - 1])
                v = v | ~((32'd1 << (8 * nb)) - 1);
            e_rd = v;
        end
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; wecnt = 0; got = 1'b0; we_addr = 0; we_data = 0;
        while (cyc <= 8 && !got) begin
            if (mem_we) begin
                wecnt++; we_addr = mem_addr; we_data = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1;
                req_valid = 1'b0;
            end else begin
                check("busy_ready", {31'd0, req_ready}, 32'd0);
                // Junk request while busy must be ignored.
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom); req_size = 2'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) cyc = 99;
        check("latency", 32'(cyc), 32'(e_lat));
        check("resp_ready", {31'd0, req_ready}, 32'd0);
        check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        check("resp_rdata", resp_rdata, e_rd);
        check("we_count", 32'(wecnt), (!e_err && w) ? 32'd1 : 32'd0);
        if (!e_err && w) begin
            check("we_addr", we_addr, a & ~32'd3);
            check("we_data", we_data, e_word);
        end
        if (e_err) m_errs++;
        else if (w) m_stores++;
        else m_loads++;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_valid", {31'd0, resp_valid}, 32'd0);
        check("hold_rdata", resp_rdata, e_rd);
        check("idle_addr", mem_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int a;
        logic [1:0] sz;
        #1;
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            d = (i == 4) ? 32'h8899AABB : $urandom;
            pre_we = 1'b1; pre_idx = 8'(i); pre_data = d;
            for (int k = 0; k < 4; k++) rm[i * 4 + k] = d[31 - 8 * k -: 8];
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        check("lb_s_const", resp_rdata, 32'hFFFFFF99);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check("lh_u_const", resp_rdata, 32'h0000AABB);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check("lh_s_const", resp_rdata, 32'hFFFF8899);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h5A);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_after_sb", resp_rdata, 32'h8899AA5A);
        do_req(1'b0, 2'd2, 1'b0, 32'h16, 32'h0);
        check("mis_word_err", {31'd0, resp_err}, 32'd1);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        check("lw_top_const", resp_rdata, 32'h12345678);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h3FF, 32'hAB);
        check("sb_top_err", {31'd0, resp_err}, 32'd0);

        // Reset while a word store is in its write cycle.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_we_hi", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_lo", {31'd0, mem_we}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_maddr", mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_loads = 0; m_stores = 0; m_errs = 0;
`ifdef MEM_ACCESS_STATS_EN
        check("cnt_load_rst", 32'(load_cnt), 32'd0);
        check("cnt_store_rst", 32'(store_cnt), 32'd0);
        check("cnt_err_rst", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        check("after_rst_ready", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

        for (int n = 0; n < 200; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom_range(0, 1031);
            if ($urandom_range(0, 3) != 0)
                a = a & ~((sz == 2'd0) ? 0 : (sz == 2'd1) ? 1 : 3);
            do_req(1'($urandom), sz, 1'($urandom), 32'(a), $urandom);
        end
`ifdef MEM_ACCESS_STATS_EN
        check("cnt_load", 32'(load_cnt), 32'(m_loads));
        check("cnt_store", 32'(store_cnt), 32'(m_stores));
        check("cnt_err", 32'(err_cnt), 32'(m_errs));
`endif
        for (int i = 0; i < 256; i += 17)
            check("mem_image", mem[i], ref_word(i * 4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
